// File: rtl/rs232_tx_serialiser.sv
// Serialises the low byte of each stb/ack stream word into an 8N1/8N2 UART frame.
// All outputs are registered; one word is consumed per frame, and ack is issued only from IDLE.
module rs232_tx_serialiser #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int STOP_BITS       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_data_stb,
  output logic        in_data_ack,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned NUM_STOP     = (STOP_BITS == 2) ? 2 : 1;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic               stop_q, stop_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               last_clk;

  // Bits [31:8] of the stream word carry nothing for the line.
  logic unused_upper;
  assign unused_upper = ^in_data[31:8];

  assign last_clk    = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign in_data_ack = ack_q;
  assign tx          = tx_q;
  assign busy        = busy_q;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic; tx is computed one cycle ahead so the line is driven straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        if (in_data_stb) begin
          shift_d = in_data[7:0];
          ack_d   = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (last_clk) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (last_clk) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (last_clk) begin
          baud_d = '0;
          if (stop_q == 1'(NUM_STOP - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rs232_tx_serialiser.sv
// Directed bench for rs232_tx_serialiser: CLKS_PER_BIT = 4, one 1-stop and one 2-stop instance.
module tb_rs232_tx_serialiser;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data, in_data2;
  logic        in_data_stb, in_data_stb2;
  logic        in_data_ack, in_data_ack2;
  logic        tx, tx2;
  logic        busy, busy2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs232_tx_serialiser #(.CLOCK_FREQUENCY(16), .BAUD_RATE(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_stb(in_data_stb),
    .in_data_ack(in_data_ack), .tx(tx), .busy(busy)
  );

  rs232_tx_serialiser #(.CLOCK_FREQUENCY(16), .BAUD_RATE(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_data_stb(in_data_stb2),
    .in_data_ack(in_data_ack2), .tx(tx2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an ack on the 1-stop instance; returns the cycle it was seen.
  task automatic wait_ack(input string tag, output int t);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (in_data_ack === 1'b1) seen = 1'b1;
    end
    check({tag, " ack seen"}, 32'(seen), 32'd1);
    t = cyc;
  endtask

  // Called on the ack cycle (frame cycle 0); checks 40 frame cycles and the idle gap cycle.
  task automatic check_frame(input string tag, input logic [7:0] b);
    int    bitn;
    logic  exp_tx;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      bitn = i / 4;
      if (bitn == 0)      exp_tx = 1'b0;
      else if (bitn == 9) exp_tx = 1'b1;
      else                exp_tx = b[bitn-1];
      check($sformatf("%s tx c%0d", tag, i), 32'(tx), 32'(exp_tx));
      check($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s ack c%0d", tag, i), 32'(in_data_ack), (i == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check({tag, " gap tx"}, 32'(tx), 32'd1);
    check({tag, " gap busy"}, 32'(busy), 32'd0);
    check({tag, " gap ack"}, 32'(in_data_ack), 32'd0);
  endtask

  initial begin
    int t_raise, t0, t1, t2, bad, acks;
    bit seen;

    // Reset with stb already high: rst wins, no ack.
    rst = 1'b1; in_data = 32'h0000_0055; in_data_stb = 1'b1;
    in_data2 = 32'h0; in_data_stb2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset ack c%0d", i), 32'(in_data_ack), 32'd0);
      check($sformatf("reset tx c%0d", i), 32'(tx), 32'd1);
      check($sformatf("reset busy c%0d", i), 32'(busy), 32'd0);
      check($sformatf("reset tx2 c%0d", i), 32'(tx2), 32'd1);
    end

    // Test 1: 0x55 with one-cycle latency to the falling edge.
    rst = 1'b0; t_raise = cyc;
    wait_ack("t1", t0);
    check("t1 latency", 32'(t0 - t_raise), 32'd1);
    in_data_stb = 1'b0;
    check_frame("t1", 8'h55);

    // Test 2: only the low byte of the word goes out.
    @(negedge clk);
    in_data = 32'hDEAD_BEA5; in_data_stb = 1'b1;
    wait_ack("t2", t0);
    in_data_stb = 1'b0;
    check_frame("t2", 8'hA5);

    // Test 3: stb held across three words; falling edges 41 cycles apart.
    @(negedge clk);
    in_data = 32'h01; in_data_stb = 1'b1;
    wait_ack("t3w0", t0);
    in_data = 32'h02;
    check_frame("t3w0", 8'h01);
    wait_ack("t3w1", t1);
    check("t3 period 0-1", 32'(t1 - t0), 32'd41);
    in_data = 32'h03;
    check_frame("t3w1", 8'h02);
    wait_ack("t3w2", t2);
    check("t3 period 1-2", 32'(t2 - t1), 32'd41);
    in_data_stb = 1'b0;
    check_frame("t3w2", 8'h03);
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_data_ack !== 1'b0) acks++;
    end
    check("t3 extra acks", 32'(acks), 32'd0);

    // Test 4: reset during DATA, then a clean frame.
    in_data = 32'h55; in_data_stb = 1'b1;
    wait_ack("t4a", t0);
    in_data_stb = 1'b0;
    repeat (16) @(negedge clk);
    check("t4 pre-rst tx (bit3)", 32'(tx), 32'd0);
    check("t4 pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t4 post-rst tx", 32'(tx), 32'd1);
    check("t4 post-rst busy", 32'(busy), 32'd0);
    check("t4 post-rst ack", 32'(in_data_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    in_data = 32'h3C; in_data_stb = 1'b1;
    wait_ack("t4b", t0);
    in_data_stb = 1'b0;
    check_frame("t4b", 8'h3C);

    // Test 5: two stop bits, 0xFF, stb held so the next ack lands at cycle 45.
    in_data2 = 32'hFF; in_data_stb2 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (in_data_ack2 === 1'b1) seen = 1'b1;
    end
    check("t5 ack seen", 32'(seen), 32'd1);
    for (int i = 0; i < 44; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t5 tx c%0d", i), 32'(tx2), (i < 4) ? 32'd0 : 32'd1);
      check($sformatf("t5 busy c%0d", i), 32'(busy2), 32'd1);
      check($sformatf("t5 ack c%0d", i), 32'(in_data_ack2), (i == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("t5 c44 busy", 32'(busy2), 32'd0);
    check("t5 c44 ack", 32'(in_data_ack2), 32'd0);
    check("t5 c44 tx", 32'(tx2), 32'd1);
    @(negedge clk);
    check("t5 c45 ack", 32'(in_data_ack2), 32'd1);
    check("t5 c45 tx", 32'(tx2), 32'd0);
    in_data_stb2 = 1'b0;
    repeat (50) @(negedge clk);

    // Test 6: idle line for 1000 cycles.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || in_data_ack !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t6 idle violations", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
